// File: rtl/cache_controller.sv
// Sequencing FSM for a direct-mapped write-back cache: lookup, block writeback, refill,
// array write strobes and saturating hit/miss statistics. Carries no address or data.
module cache_controller #(
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned STAT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           req_valid,
    input  logic                           req_we,
    output logic                           req_ready,
    output logic                           latch_req,
    output logic                           resp_valid,
    input  logic                           tag_match,
    input  logic                           valid_bit,
    input  logic                           selected_dirty_bit,
    output logic                           set_selected_dirty_bit,
    output logic                           clear_selected_dirty_bit,
    output logic                           set_valid_bit,
    output logic                           load_tag,
    output logic                           write_word,
    output logic                           fill_we,
    output logic [$clog2(BLOCK_WORDS)-1:0] beat_idx,
    output logic                           mem_req_valid,
    output logic                           mem_req_we,
    input  logic                           mem_req_ready,
    input  logic                           mem_resp_valid,
    output logic [STAT_WIDTH-1:0]          hit_count,
    output logic [STAT_WIDTH-1:0]          miss_count
);

    localparam int unsigned BeatW = $clog2(BLOCK_WORDS);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {StIdle, StCompare, StWriteback, StAllocate, StFill} state_e;

    state_e                state_q, state_d;
    logic [BeatW-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  first_q, first_d;
    logic [STAT_WIDTH-1:0] hit_q, hit_d;
    logic [STAT_WIDTH-1:0] miss_q, miss_d;

    logic hit;
    assign hit = tag_match & valid_bit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            first_q <= 1'b0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            first_q <= first_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d                  = state_q;
        cnt_d                    = cnt_q;
        we_d                     = we_q;
        first_d                  = first_q;
        hit_d                    = hit_q;
        miss_d                   = miss_q;
        req_ready                = 1'b0;
        latch_req                = 1'b0;
        resp_valid               = 1'b0;
        set_selected_dirty_bit   = 1'b0;
        clear_selected_dirty_bit = 1'b0;
        set_valid_bit            = 1'b0;
        load_tag                 = 1'b0;
        write_word               = 1'b0;
        fill_we                  = 1'b0;
        mem_req_valid            = 1'b0;
        mem_req_we               = 1'b0;
        // Strobes are suppressed while reset is asserted so an aborted transaction
        // cannot write the arrays in the cycle reset is sampled.
        if (reset_n) begin
            unique case (state_q)
                StIdle: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        latch_req = 1'b1;
                        we_d      = req_we;
                        first_d   = 1'b1;
                        state_d   = StCompare;
                    end
                end
                StCompare: begin
                    first_d = 1'b0;
                    if (hit) begin
                        resp_valid = 1'b1;
                        if (we_q) begin
                            write_word             = 1'b1;
                            set_selected_dirty_bit = 1'b1;
                        end
                        if (first_q && hit_q != '1) hit_d = hit_q + STAT_WIDTH'(1);
                        state_d = StIdle;
                    end else begin
                        if (first_q && miss_q != '1) miss_d = miss_q + STAT_WIDTH'(1);
                        state_d = (valid_bit && selected_dirty_bit) ? StWriteback : StAllocate;
                    end
                end
                StWriteback: begin
                    mem_req_valid = 1'b1;
                    mem_req_we    = 1'b1;
                    if (mem_req_ready) begin
                        cnt_d = cnt_q + BeatW'(1);
                        if (cnt_q == LastBeat) begin
                            clear_selected_dirty_bit = 1'b1;
                            state_d                  = StAllocate;
                        end
                    end
                end
                StAllocate: begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) state_d = StFill;
                end
                StFill: begin
                    if (mem_resp_valid) begin
                        fill_we = 1'b1;
                        cnt_d   = cnt_q + BeatW'(1);
                        if (cnt_q == LastBeat) begin
                            set_valid_bit = 1'b1;
                            load_tag      = 1'b1;
                            state_d       = StCompare;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign beat_idx   = cnt_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller: a tiny one-set datapath/memory model reacts to the
// strobes, and per-request outcomes are predicted from the lookup status alone.
module tb_cache_controller;

    localparam int unsigned BW     = 4;
    localparam int unsigned SW     = 4;
    localparam int          MaxCnt = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0, req_we = 1'b0;
    logic          req_ready, latch_req, resp_valid;
    logic          tag_match = 1'b0, valid_bit = 1'b0, selected_dirty_bit = 1'b0;
    logic          set_selected_dirty_bit, clear_selected_dirty_bit, set_valid_bit, load_tag;
    logic          write_word, fill_we;
    logic [1:0]    beat_idx;
    logic          mem_req_valid, mem_req_we;
    logic          mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
    logic [SW-1:0] hit_count, miss_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    cache_controller #(.BLOCK_WORDS(BW), .STAT_WIDTH(SW)) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .req_valid                (req_valid),
        .req_we                   (req_we),
        .req_ready                (req_ready),
        .latch_req                (latch_req),
        .resp_valid               (resp_valid),
        .tag_match                (tag_match),
        .valid_bit                (valid_bit),
        .selected_dirty_bit       (selected_dirty_bit),
        .set_selected_dirty_bit   (set_selected_dirty_bit),
        .clear_selected_dirty_bit (clear_selected_dirty_bit),
        .set_valid_bit            (set_valid_bit),
        .load_tag                 (load_tag),
        .write_word               (write_word),
        .fill_we                  (fill_we),
        .beat_idx                 (beat_idx),
        .mem_req_valid            (mem_req_valid),
        .mem_req_we               (mem_req_we),
        .mem_req_ready            (mem_req_ready),
        .mem_resp_valid           (mem_resp_valid),
        .hit_count                (hit_count),
        .miss_count               (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One request; rwait < 0 gives random mem_req_ready, else ready after rwait low cycles.
    task automatic run_req(input bit we, input bit tm, input bit v, input bit d, input int rwait);
        bit hit, wb, rd_acc, pend, lt_now, sv_now, sd_now, cd_now;
        int cyc, wb_n, fill_n, ww, sd, cd, sv, lt, rdreq, rsp, bad, lf, wcnt, resp_cyc, mrv;
        hit = tm & v;
        wb  = !hit && v && d;
        {rd_acc, pend} = '0;
        {cyc, wb_n, fill_n, ww, sd, cd, sv, lt, rdreq, rsp, bad, lf, wcnt, resp_cyc, mrv} = '0;
        if (hit) exp_hits = (exp_hits == MaxCnt) ? exp_hits : exp_hits + 1;
        else exp_misses = (exp_misses == MaxCnt) ? exp_misses : exp_misses + 1;
        @(negedge clk);
        req_valid = 1'b1; req_we = we;
        tag_match = tm; valid_bit = v; selected_dirty_bit = d;
        while (rsp == 0 && cyc < 500) begin
            mem_req_ready  = (rwait < 0) ? 1'($urandom_range(0, 1)) : (wcnt >= rwait);
            mem_resp_valid = rd_acc ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 3) == 0);
            #1;
            cyc++;
            if (latch_req != (cyc == 1) || req_ready != (cyc == 1)) bad++;
            if (set_selected_dirty_bit && clear_selected_dirty_bit) bad++;
            if (write_word != set_selected_dirty_bit || (write_word && !resp_valid)) bad++;
            if (pend && !mem_req_valid) bad++;
            pend = mem_req_valid && !mem_req_ready;
            if (mem_req_valid) mrv++;
            if (clear_selected_dirty_bit != (mem_req_valid && mem_req_we && mem_req_ready
                                             && wb_n == BW - 1)) bad++;
            if (mem_req_valid) begin
                wcnt = mem_req_ready ? 0 : wcnt + 1;
                if (mem_req_we && mem_req_ready) begin
                    if (int'(beat_idx) != wb_n) bad++;
                    wb_n++;
                end
                if (!mem_req_we && mem_req_ready) rdreq++;
            end
            if (fill_we != (rd_acc && mem_resp_valid && fill_n < BW)) bad++;
            if (set_valid_bit != load_tag || (set_valid_bit && !fill_we)) bad++;
            if (fill_we) begin
                if (int'(beat_idx) != fill_n) bad++;
                if (set_valid_bit != (fill_n == BW - 1)) bad++;
                fill_n++;
                lf = cyc;
            end
            ww += int'(write_word); sd += int'(set_selected_dirty_bit);
            cd += int'(clear_selected_dirty_bit);
            sv += int'(set_valid_bit); lt += int'(load_tag);
            if (resp_valid) begin rsp++; resp_cyc = cyc; end
            if (mem_req_valid && !mem_req_we && mem_req_ready) rd_acc = 1'b1;
            lt_now = load_tag; sv_now = set_valid_bit;
            sd_now = set_selected_dirty_bit; cd_now = clear_selected_dirty_bit;
            @(negedge clk);
            if (lt_now) tag_match = 1'b1;
            if (sv_now) valid_bit = 1'b1;
            if (sd_now) selected_dirty_bit = 1'b1;
            if (cd_now) selected_dirty_bit = 1'b0;
            if (rsp != 0) begin req_valid = 1'b0; mem_resp_valid = 1'b0; end
        end
        chk("resp_count", rsp, 1);
        chk("protocol", bad, 0);
        chk("latency", resp_cyc, hit ? 2 : lf + 1);
        chk("wb_beats", wb_n, wb ? BW : 0);
        chk("clr_dirty", cd, wb ? 1 : 0);
        chk("rd_req", rdreq, hit ? 0 : 1);
        chk("fill_beats", fill_n, hit ? 0 : BW);
        chk("set_valid", sv, hit ? 0 : 1);
        chk("load_tag", lt, hit ? 0 : 1);
        chk("write_word", ww, we ? 1 : 0);
        chk("set_dirty", sd, we ? 1 : 0);
        chk("mem_req_seen", mrv != 0, !hit);
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_misses);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_beat", beat_idx, 0);
        chk("rst_mreq", mem_req_valid, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_miss", miss_count, 0);

        // Clean read miss, reset asserted after two fill beats.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; tag_match = 1'b0; valid_bit = 1'b0;
        selected_dirty_bit = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); mem_resp_valid = 1'b1;
        #1; chk("pre_rst_fill", fill_we, 1);
        @(negedge clk);
        @(negedge clk); reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; chk("fill_in_rst", fill_we, 0);
            @(negedge clk);
        end
        reset_n = 1'b1; mem_resp_valid = 1'b0;
        #1;
        chk("abort_ready", req_ready, 1);
        chk("abort_beat", beat_idx, 0);
        chk("abort_hits", hit_count, 0);
        chk("abort_miss", miss_count, 0);
        exp_hits = 0; exp_misses = 0;

        run_req(1'b0, 1'b1, 1'b1, 1'b0, 0);   // read hit
        run_req(1'b1, 1'b1, 1'b1, 1'b0, 0);   // write hit
        run_req(1'b0, 1'b0, 1'b1, 1'b1, 2);   // dirty read miss, slow memory
        run_req(1'b1, 1'b0, 1'b0, 1'b0, 0);   // write miss on invalid set
        run_req(1'b1, 1'b1, 1'b0, 1'b1, -1);  // tag match but invalid: miss, no writeback

        for (int i = 0; i < (1 << SW) + 3; i++) run_req(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, 0);
        chk("hit_sat", hit_count, MaxCnt);

        @(negedge clk);
        mem_resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; chk("stray_resp", fill_we, 0);
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;

        for (int i = 0; i < 40; i++)
            run_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)) - 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
